// File: rtl/calc_pkg.sv
// Shared encodings for the keypad calculator: FSM states, operator codes and the
// largest value a DIGITS-digit display can show.
package calc_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    RESULT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_CLR = 2'd3
  } op_t;

  function automatic longint unsigned calc_maxval(input int digits);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/calc_engine_if.sv
// Keypad event / display bundle between the key decoder (master) and calc_engine (slave).
interface calc_engine_if #(
  parameter int DIGITS = 4
);
  logic                  digit_valid;
  logic [3:0]            digit;
  logic                  op_valid;
  logic [1:0]            op;
  logic                  eq_valid;
  logic [4*DIGITS-1:0]   disp_bcd;
  logic                  disp_neg;
  logic                  overflow;
  logic                  busy;
  logic                  result_valid;
  logic [1:0]            state;

  modport master (
    output digit_valid, digit, op_valid, op, eq_valid,
    input  disp_bcd, disp_neg, overflow, busy, result_valid, state
  );

  modport slave (
    input  digit_valid, digit, op_valid, op, eq_valid,
    output disp_bcd, disp_neg, overflow, busy, result_valid, state
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Latency: done rises BIN_W cycles after start; drops the cycle after it is seen.
// No backpressure: start reloads, abort drops the conversion in progress.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    sh;
  logic [CW-1:0]       cnt;
  logic                active;
  logic [4*DIGITS-1:0] adj;

  // Add 3 to every digit >= 5 so the following left shift carries correctly.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      sh     <= '0;
      cnt    <= '0;
      active <= 1'b0;
      bcd    <= '0;
    end else if (start) begin
      sh     <= bin;
      cnt    <= CW'(BIN_W);
      active <= 1'b1;
      bcd    <= '0;
    end else if (active) begin
      if (cnt != '0) begin
        bcd <= {adj[4*DIGITS-2:0], sh[BIN_W-1]};
        sh  <= {sh[BIN_W-2:0], 1'b0};
        cnt <= cnt - 1'b1;
      end else begin
        active <= 1'b0;
      end
    end
  end

  assign done = active && (cnt == '0);

endmodule

// File: rtl/calc_engine.sv
// Keypad calculator: operand entry, add/sub/mul, sequential BCD conversion of the result.
// Latency: result_valid pulses BIN_W+2 cycles after the accepted equals key.
// No backpressure: keys other than clear are dropped while busy.
module calc_engine
  import calc_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic          clk,
  input  logic          rst,
  calc_engine_if.slave  kp
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int RW = 2 * BIN_W;
  localparam logic [RW-1:0] MAXV = RW'(calc_maxval(DIGITS));

  state_t              st;
  logic                conv;
  op_t                 pend;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] a_bcd, b_bcd, disp_q;
  logic [BIN_W-1:0]    a_bin, b_bin, res_bin;
  logic                res_neg, res_ovf;
  logic                neg_q, ovf_q, busy_q, rv_q;

  logic                clr, ev_eq, ev_op, dig_acc;
  op_t                 new_op;
  logic [4*DIGITS-1:0] ent_bcd_nx;
  logic [BIN_W-1:0]    ent_bin_nx;
  logic [RW-1:0]       wa, wb, alu_r;
  logic                alu_neg, alu_ovf;
  logic [BIN_W-1:0]    alu_bin;
  logic                cv_done;
  logic [4*DIGITS-1:0] cv_bcd;

  // Priority clear > eq > op > digit: only the top event present is considered.
  assign clr     = kp.op_valid && (kp.op == 2'(OP_CLR));
  assign ev_eq   = kp.eq_valid;
  assign ev_op   = !kp.eq_valid && kp.op_valid;
  assign dig_acc = !kp.eq_valid && !kp.op_valid && kp.digit_valid && (kp.digit <= 4'd9);
  assign new_op  = op_t'(kp.op);

  assign ent_bcd_nx = ((st == ENTER_A ? a_bcd : b_bcd) << 4) | (4*DIGITS)'(kp.digit);
  assign ent_bin_nx = (st == ENTER_A ? a_bin : b_bin) * BIN_W'(10) + BIN_W'(kp.digit);

  always_comb begin
    wa      = RW'(a_bin);
    wb      = RW'(b_bin);
    alu_neg = 1'b0;
    alu_r   = wa + wb;
    case (pend)
      OP_SUB: begin
        if (wa < wb) begin
          alu_r   = wb - wa;
          alu_neg = 1'b1;
        end else begin
          alu_r   = wa - wb;
        end
      end
      OP_MUL:  alu_r = wa * wb;
      default: alu_r = wa + wb;
    endcase
    alu_ovf = alu_r > MAXV;
    alu_bin = alu_ovf ? '0 : alu_r[BIN_W-1:0];
  end

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .abort (clr),
    .start (st == CALC && !conv),
    .bin   (alu_bin),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      st      <= ENTER_A;
      conv    <= 1'b0;
      pend    <= OP_ADD;
      cnt     <= '0;
      a_bcd   <= '0;
      a_bin   <= '0;
      b_bcd   <= '0;
      b_bin   <= '0;
      res_bin <= '0;
      res_neg <= 1'b0;
      res_ovf <= 1'b0;
      disp_q  <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      case (st)
        ENTER_A, ENTER_B: begin
          if (st == ENTER_B && ev_eq) begin
            st     <= CALC;
            busy_q <= 1'b1;
          end else if (ev_op) begin
            // In ENTER_B an operator only replaces the pending one before B is started.
            if (st == ENTER_A || cnt == '0) pend <= new_op;
            if (st == ENTER_A) begin
              cnt    <= '0;
              b_bcd  <= '0;
              b_bin  <= '0;
              disp_q <= '0;
              st     <= ENTER_B;
            end
          end else if (dig_acc && cnt < CW'(DIGITS)) begin
            cnt    <= cnt + 1'b1;
            disp_q <= ent_bcd_nx;
            if (st == ENTER_A) begin
              a_bcd <= ent_bcd_nx;
              a_bin <= ent_bin_nx;
            end else begin
              b_bcd <= ent_bcd_nx;
              b_bin <= ent_bin_nx;
            end
          end
        end
        CALC: begin
          if (!conv) begin
            conv    <= 1'b1;
            res_bin <= alu_bin;
            res_neg <= alu_neg;
            res_ovf <= alu_ovf;
          end else if (cv_done) begin
            conv   <= 1'b0;
            busy_q <= 1'b0;
            disp_q <= cv_bcd;
            neg_q  <= res_neg;
            ovf_q  <= res_ovf;
            rv_q   <= 1'b1;
            st     <= RESULT;
          end
        end
        RESULT: begin
          if (ev_eq) begin
            st <= RESULT;
          end else if (ev_op) begin
            if (!neg_q && !ovf_q) begin
              a_bin  <= res_bin;
              a_bcd  <= disp_q;
              pend   <= new_op;
              cnt    <= '0;
              b_bcd  <= '0;
              b_bin  <= '0;
              disp_q <= '0;
              st     <= ENTER_B;
            end
          end else if (dig_acc) begin
            a_bcd  <= (4*DIGITS)'(kp.digit);
            a_bin  <= BIN_W'(kp.digit);
            cnt    <= CW'(1);
            disp_q <= (4*DIGITS)'(kp.digit);
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            st     <= ENTER_A;
          end
        end
        default: st <= ENTER_A;
      endcase
    end
  end

  assign kp.disp_bcd     = disp_q;
  assign kp.disp_neg     = neg_q;
  assign kp.overflow     = ovf_q;
  assign kp.busy         = busy_q;
  assign kp.result_valid = rv_q;
  assign kp.state        = st;

endmodule

// File: tb/tb_calc_engine.sv
// Bench for calc_engine: directed key sequences plus random key streams against a
// value-level calculator model.
module tb_calc_engine;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_engine_if #(.DIGITS(DIGITS)) ifc ();

  calc_engine #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (ifc.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Calculator model in plain integers.
  int      m_st, m_cnt, m_op;
  longint  m_a, m_b, m_res, m_disp, m_maxv;
  bit      m_neg, m_ovf, m_busy;
  longint  c_res;
  bit      c_neg, c_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] to_bcd(input longint v);
    logic [63:0] r;
    longint x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (64'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_op = 0;
    m_a = 0; m_b = 0; m_res = 0; m_disp = 0;
    m_neg = 0; m_ovf = 0; m_busy = 0;
  endtask

  // kind: 0 digit, 1 operator (0..2), 2 equals, 3 clear
  task automatic model_key(input int kind, input int val, output bit started);
    started = 0;
    if (kind == 3) begin
      model_reset();
    end else if (!m_busy) begin
      case (m_st)
        0, 1: begin
          if (kind == 0 && val <= 9 && m_cnt < DIGITS) begin
            if (m_st == 0) begin m_a = m_a * 10 + val; m_disp = m_a; end
            else           begin m_b = m_b * 10 + val; m_disp = m_b; end
            m_cnt++;
          end else if (kind == 1) begin
            if (m_st == 0) begin
              m_op = val; m_cnt = 0; m_b = 0; m_disp = 0; m_st = 1;
            end else if (m_cnt == 0) begin
              m_op = val;
            end
          end else if (kind == 2 && m_st == 1) begin
            c_neg = 0;
            if (m_op == 0) c_res = m_a + m_b;
            else if (m_op == 1) begin
              c_neg = m_a < m_b;
              c_res = c_neg ? m_b - m_a : m_a - m_b;
            end else c_res = m_a * m_b;
            c_ovf = c_res > m_maxv;
            if (c_ovf) c_res = 0;
            m_st = 2; m_busy = 1; started = 1;
          end
        end
        3: begin
          if (kind == 0 && val <= 9) begin
            m_a = val; m_cnt = 1; m_disp = val; m_neg = 0; m_ovf = 0; m_st = 0;
          end else if (kind == 1 && !m_neg && !m_ovf) begin
            m_a = m_res; m_op = val; m_cnt = 0; m_b = 0; m_disp = 0; m_st = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle_in();
    ifc.digit_valid = 0; ifc.digit = 0;
    ifc.op_valid = 0; ifc.op = 0; ifc.eq_valid = 0;
  endtask

  task automatic drive(input int kind, input int val);
    idle_in();
    case (kind)
      0: begin ifc.digit_valid = 1; ifc.digit = 4'(val); end
      1: begin ifc.op_valid = 1; ifc.op = 2'(val); end
      2: ifc.eq_valid = 1;
      default: begin ifc.op_valid = 1; ifc.op = 2'd3; end
    endcase
  endtask

  task automatic check_all(input string t, input bit exp_rv);
    chk({t, " disp_bcd"}, 64'(ifc.disp_bcd), to_bcd(m_disp));
    chk({t, " disp_neg"}, 64'(ifc.disp_neg), 64'(m_neg));
    chk({t, " overflow"}, 64'(ifc.overflow), 64'(m_ovf));
    chk({t, " busy"}, 64'(ifc.busy), 64'(m_busy));
    chk({t, " state"}, 64'(ifc.state), 64'(m_st));
    chk({t, " result_valid"}, 64'(ifc.result_valid), 64'(exp_rv));
  endtask

  // Cycle k after the equals edge; an abort at cycle k replaces that cycle's key.
  task automatic run_calc(input int abort_at, input bit use_rst);
    bit dummy;
    for (int k = 1; k <= BIN_W + 2; k++) begin
      if (k == abort_at) begin
        if (use_rst) rst = 1'b1;
        else drive(3, 0);
      end else if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 2))
          0: drive(0, $urandom_range(0, 9));
          1: drive(1, $urandom_range(0, 2));
          default: drive(2, 0);
        endcase
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle_in();
      if (k == abort_at) begin
        model_key(3, 0, dummy);
        check_all("abort", 1'b0);
        for (int j = 0; j < BIN_W + 4; j++) begin
          @(negedge clk);
          chk("abort quiet result_valid", 64'(ifc.result_valid), 64'd0);
        end
        chk("abort quiet state", 64'(ifc.state), 64'd0);
        return;
      end
      if (k < BIN_W + 2) begin
        check_all("busy", 1'b0);
      end else begin
        m_st = 3; m_busy = 0; m_res = c_res; m_disp = c_res;
        m_neg = c_neg; m_ovf = c_ovf;
        check_all("result", 1'b1);
      end
    end
  endtask

  task automatic do_key(input int kind, input int val, input int abort_at, input bit use_rst);
    bit started;
    drive(kind, val);
    @(posedge clk);
    @(negedge clk);
    idle_in();
    model_key(kind, val, started);
    check_all("key", 1'b0);
    if (started) run_calc(abort_at, use_rst);
  endtask

  task automatic keys(input string s, input int abort_at, input bit use_rst);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      int kind, val;
      c = s[i];
      kind = 0;
      val = 0;
      if (c >= "0" && c <= "9") val = int'(c - "0");
      else if (c == "A") val = 10;
      else if (c == "+") kind = 1;
      else if (c == "-") begin kind = 1; val = 1; end
      else if (c == "*") begin kind = 1; val = 2; end
      else if (c == "=") kind = 2;
      else kind = 3;
      do_key(kind, val, abort_at, use_rst);
    end
  endtask

  initial begin
    m_maxv = 1;
    for (int i = 0; i < DIGITS; i++) m_maxv = m_maxv * 10;
    m_maxv = m_maxv - 1;
    model_reset();
    idle_in();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("reset", 1'b0);

    keys("12+34=", 0, 0);
    chk("t1 sum", 64'(ifc.disp_bcd), 64'h0046);
    keys("5-9=", 0, 0);
    chk("t2 diff", 64'(ifc.disp_bcd), 64'h0004);
    chk("t2 neg", 64'(ifc.disp_neg), 64'd1);
    keys("99*99=", 0, 0);
    chk("t3 prod", 64'(ifc.disp_bcd), 64'h9801);
    keys("9999*2=", 0, 0);
    chk("t3 ovf", 64'(ifc.overflow), 64'd1);
    chk("t3 ovf bcd", 64'(ifc.disp_bcd), 64'h0);
    keys("*", 0, 0);
    chk("t3 op after ovf", 64'(ifc.state), 64'd3);
    keys("C12345A", 0, 0);
    chk("t4 entry", 64'(ifc.disp_bcd), 64'h1234);
    keys("C2+3=", 0, 0);
    chk("t5 first", 64'(ifc.disp_bcd), 64'h0005);
    keys("*4=", 0, 0);
    chk("t5 chain", 64'(ifc.disp_bcd), 64'h0020);
    keys("C5+-3=", 0, 0);
    chk("t5 op replace", 64'(ifc.disp_bcd), 64'h0002);
    keys("C12+34=", 6, 0);
    chk("t6 clear state", 64'(ifc.state), 64'd0);
    keys("7*8=", BIN_W, 1);
    chk("t6 rst bcd", 64'(ifc.disp_bcd), 64'd0);

    for (int n = 0; n < 400; n++) begin
      int r, kind, val, ab;
      r = int'($urandom_range(0, 99));
      if (r < 50) begin kind = 0; val = (r < 46) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15)); end
      else if (r < 75) begin kind = 1; val = int'($urandom_range(0, 2)); end
      else if (r < 96) begin kind = 2; val = 0; end
      else begin kind = 3; val = 0; end
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, BIN_W + 1)) : 0;
      do_key(kind, val, ab, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
